// File: rtl/clb_config_loader.sv
// -----------------------------------------------------------------------------
// clb_config_loader
//
// Configuration-load stage in front of a logic slice. Collects the slice
// configuration bitstream as WORD_W-bit words over a valid/ready handshake,
// assembles one full frame, then commits it by holding the slice's parallel
// config buses steady and pulsing cen for CEN_HOLD cclk cycles.
//
// Ports:
//   cclk                  config clock, all state changes on its rising edge
//   rst_n                 asynchronous active-low reset
//   start                 begin (or restart) a frame load
//   cfg_word / cfg_valid  incoming config word and its valid flag
//   cfg_ready             loader accepts a word this cycle (LOAD only)
//   luts_config_in        LUT configuration bits
//   inter_lut_mux_config  inter-LUT mux configuration
//   config_use_cc         carry-chain enable
//   regs_config_in        flip-flop initial values
//   cen                   config enable to the slice, registered
//   busy                  high while loading or committing
//   done                  frame committed; held until the next start
// -----------------------------------------------------------------------------
module clb_config_loader #(
    parameter int S_XX_BASE = 4,
    parameter int NUM_LUTS  = 4,
    parameter int WORD_W    = 8,
    parameter int CEN_HOLD  = 2,
    localparam int CFG_SIZE = 2 * (2 ** S_XX_BASE) + 1,
    localparam int MUX_LVLS = $clog2(NUM_LUTS),
    localparam int FRAME_W  = CFG_SIZE * NUM_LUTS + MUX_LVLS + 1 + 2 * NUM_LUTS,
    localparam int NWORDS   = (FRAME_W + WORD_W - 1) / WORD_W
) (
    input  logic                         cclk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [WORD_W-1:0]            cfg_word,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    output logic [CFG_SIZE*NUM_LUTS-1:0] luts_config_in,
    output logic [MUX_LVLS-1:0]          inter_lut_mux_config,
    output logic                         config_use_cc,
    output logic [2*NUM_LUTS-1:0]        regs_config_in,
    output logic                         cen,
    output logic                         busy,
    output logic                         done
);

    localparam int FRAME_BITS = NWORDS * WORD_W;
    localparam int LUT_BITS   = CFG_SIZE * NUM_LUTS;
    localparam int CNT_W      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int HOLD_W     = $clog2(CEN_HOLD + 1);

    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(NWORDS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CEN_HOLD);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        word_cnt_q, word_cnt_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic                    cen_q, cen_d;
    logic                    shift_en;
    logic [FRAME_BITS-1:0]   frame_q;

    // Next-state logic. COMMIT spends one cycle arming the cen register,
    // then CEN_HOLD cycles with cen high, so cen rises the edge after the
    // last word is accepted and done follows CEN_HOLD edges later.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // through the case statement can leave it unassigned and infer a latch.
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        hold_cnt_d = hold_cnt_q;
        cen_d      = 1'b0;
        shift_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    word_cnt_d = '0;
                end
            end

            LOAD: begin
                // start outranks a word presented in the same cycle; the
                // frame register is not cleared because a full load overwrites it.
                if (start) begin
                    word_cnt_d = '0;
                end else if (cfg_valid) begin
                    shift_en = 1'b1;
                    if (word_cnt_q == LAST_WORD) begin
                        state_d    = COMMIT;
                        hold_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
            end

            COMMIT: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = DONE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    cen_d      = 1'b1;
                end
            end

            DONE: begin
                if (start) begin
                    state_d    = LOAD;
                    word_cnt_d = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            hold_cnt_q <= '0;
            cen_q      <= 1'b0;
            // NOTE: the frame register is reset because it drives the slice
            // config buses directly, which must read all-zero out of reset and
            // must not expose a partial frame after a mid-load reset.
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            cen_q      <= cen_d;
            // New word enters at the top; after NWORDS accepts the first word
            // has walked down to frame_q[WORD_W-1:0].
            if (shift_en) begin
                frame_q <= {cfg_word, frame_q[FRAME_BITS-1:WORD_W]};
            end
        end
    end

    assign cfg_ready = (state_q == LOAD);
    assign busy      = (state_q == LOAD) || (state_q == COMMIT);
    assign done      = (state_q == DONE);
    assign cen       = cen_q;

    assign luts_config_in       = frame_q[LUT_BITS-1:0];
    assign inter_lut_mux_config = frame_q[LUT_BITS +: MUX_LVLS];
    assign config_use_cc        = frame_q[LUT_BITS + MUX_LVLS];
    assign regs_config_in       = frame_q[LUT_BITS + MUX_LVLS + 1 +: 2 * NUM_LUTS];

    // Padding bits above the frame are shifted through but never used.
    generate
        if (FRAME_BITS > FRAME_W) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^frame_q[FRAME_BITS-1:FRAME_W];
        end
    endgenerate

endmodule

// File: tb/tb_clb_config_loader.sv
// -----------------------------------------------------------------------------
// tb_clb_config_loader
//
// Self-checking bench for clb_config_loader. Each frame is a list of words;
// the expected slice buses are the words laid end to end (word 0 lowest) and
// sliced by the frame layout. Commit timing is checked cycle by cycle against
// the documented latency: cen high for CEN_HOLD cycles starting the edge after
// the last accept, done from the edge after that.
// -----------------------------------------------------------------------------
module tb_clb_config_loader;

    localparam int S_XX_BASE = 4;
    localparam int NUM_LUTS  = 4;
    localparam int WORD_W    = 8;
    localparam int CEN_HOLD  = 2;
    localparam int CFG_SIZE  = 2 * (2 ** S_XX_BASE) + 1;
    localparam int MUX_LVLS  = $clog2(NUM_LUTS);
    localparam int LUT_BITS  = CFG_SIZE * NUM_LUTS;
    localparam int FRAME_W   = LUT_BITS + MUX_LVLS + 1 + 2 * NUM_LUTS;
    localparam int NWORDS    = (FRAME_W + WORD_W - 1) / WORD_W;

    logic                  cclk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [WORD_W-1:0]     cfg_word;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [LUT_BITS-1:0]   luts_config_in;
    logic [MUX_LVLS-1:0]   inter_lut_mux_config;
    logic                  config_use_cc;
    logic [2*NUM_LUTS-1:0] regs_config_in;
    logic                  cen;
    logic                  busy;
    logic                  done;

    int checks   = 0;
    int failures = 0;

    logic [WORD_W-1:0]        words [NWORDS];
    logic [NWORDS*WORD_W-1:0] exp_frame;

    int   cen_cycles = 0;
    int   cen_rises  = 0;
    logic cen_prev   = 1'b0;

    always #5 cclk = ~cclk;

    clb_config_loader #(
        .S_XX_BASE (S_XX_BASE),
        .NUM_LUTS  (NUM_LUTS),
        .WORD_W    (WORD_W),
        .CEN_HOLD  (CEN_HOLD)
    ) dut (
        .cclk                 (cclk),
        .rst_n                (rst_n),
        .start                (start),
        .cfg_word             (cfg_word),
        .cfg_valid            (cfg_valid),
        .cfg_ready            (cfg_ready),
        .luts_config_in       (luts_config_in),
        .inter_lut_mux_config (inter_lut_mux_config),
        .config_use_cc        (config_use_cc),
        .regs_config_in       (regs_config_in),
        .cen                  (cen),
        .busy                 (busy),
        .done                 (done)
    );

    // Counts cen-high cycles and distinct cen pulses.
    always @(negedge cclk) begin
        if (cen) cen_cycles++;
        if (cen && !cen_prev) cen_rises++;
        cen_prev = cen;
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NWORDS*WORD_W-1:0] build_frame();
        logic [NWORDS*WORD_W-1:0] f;
        f = '0;
        for (int i = 0; i < NWORDS; i++) f[i*WORD_W +: WORD_W] = words[i];
        return f;
    endfunction

    task automatic check_cfg(input string tag);
        check({tag, "_luts"}, luts_config_in,       exp_frame[LUT_BITS-1:0]);
        check({tag, "_mux"},  inter_lut_mux_config, exp_frame[LUT_BITS +: MUX_LVLS]);
        check({tag, "_cc"},   config_use_cc,        exp_frame[LUT_BITS + MUX_LVLS]);
        check({tag, "_regs"}, regs_config_in,       exp_frame[LUT_BITS + MUX_LVLS + 1 +: 2 * NUM_LUTS]);
    endtask

    task automatic check_zero(input string tag);
        check(tag, {luts_config_in, inter_lut_mux_config, config_use_cc, regs_config_in,
                    cen, cfg_ready, busy, done}, '0);
    endtask

    // Starts a load from the current state (presenting a junk word that must be
    // dropped), streams words[] and checks the commit sequence. Called and
    // returns at a negedge. With rst_in_commit, reset is pulsed on the first
    // cen cycle instead of finishing the commit.
    task automatic run_load(input bit throttle, input bit rst_in_commit);
        int got, guard, c0, r0;
        bit v;
        c0 = cen_cycles;
        r0 = cen_rises;
        exp_frame = build_frame();

        start = 1'b1; cfg_valid = 1'b1; cfg_word = ~words[0];
        @(negedge cclk);
        start = 1'b0;
        check("load_ready", cfg_ready, 1);
        check("load_busy", busy, 1);
        check("load_done_clr", done, 0);

        got = 0; guard = 0;
        while (got < NWORDS && guard < 10 * NWORDS) begin
            v = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_valid = v;
            cfg_word  = v ? words[got] : WORD_W'($urandom);
            @(negedge cclk);
            guard++;
            if (v) got++;
            if (got < NWORDS) begin
                check("load_ready_hold", cfg_ready, 1);
                check("load_no_cen", cen, 0);
            end
        end
        check("load_words_sent", got, NWORDS);
        cfg_valid = 1'b0;

        check("commit_lead_cen", cen, 0);
        check("commit_lead_busy", busy, 1);
        check("commit_lead_ready", cfg_ready, 0);

        for (int k = 1; k <= CEN_HOLD; k++) begin
            if (k == 1) begin
                // start and data during COMMIT must both be ignored
                start = 1'b1; cfg_valid = 1'b1; cfg_word = ~words[NWORDS-1];
            end
            @(negedge cclk);
            start = 1'b0; cfg_valid = 1'b0;
            check("commit_cen", cen, 1);
            if (rst_in_commit) begin
                #1 rst_n = 1'b0;
                #1;
                check_zero("reset_in_commit");
                @(negedge cclk);
                rst_n = 1'b1;
                return;
            end
            check("commit_busy", busy, 1);
            check("commit_done", done, 0);
            check("commit_ready", cfg_ready, 0);
        end

        @(negedge cclk);
        check("done_set", done, 1);
        check("done_cen", cen, 0);
        check("done_busy", busy, 0);
        check("done_ready", cfg_ready, 0);
        check_cfg("frame");
        check("cen_cycles", cen_cycles - c0, CEN_HOLD);
        check("cen_pulses", cen_rises - r0, 1);

        repeat (3) begin
            cfg_valid = 1'b1; cfg_word = WORD_W'($urandom);
            @(negedge cclk);
        end
        cfg_valid = 1'b0;
        check("done_hold", done, 1);
        check_cfg("frame_after_done_valid");
    endtask

    initial begin
        int c_partial;
        rst_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_word = '0;

        // Reset, then idle with valid asserted and no start.
        repeat (3) begin
            @(negedge cclk);
            check_zero("in_reset");
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cfg_valid = 1'b1; cfg_word = WORD_W'($urandom);
            @(negedge cclk);
            check_zero("idle_ignore");
        end
        cfg_valid = 1'b0;

        // Full load with the counting pattern, back to back.
        for (int i = 0; i < NWORDS; i++) words[i] = WORD_W'(i);
        run_load(1'b0, 1'b0);
        check("luts_byte0", luts_config_in[7:0], 8'h00);
        check("luts_byte1", luts_config_in[15:8], 8'h01);
        check("regs_top", regs_config_in, exp_frame[142:135]);

        // Random frame, throttled.
        for (int i = 0; i < NWORDS; i++) words[i] = WORD_W'($urandom);
        run_load(1'b1, 1'b0);

        // Counting pattern again, throttled; outputs must match the first load.
        for (int i = 0; i < NWORDS; i++) words[i] = WORD_W'(i);
        run_load(1'b1, 1'b0);

        // Restart mid-load: 7 words, then a full all-ones frame.
        start = 1'b1;
        @(negedge cclk);
        start = 1'b0;
        c_partial = cen_cycles;
        for (int i = 0; i < 7; i++) begin
            cfg_valid = 1'b1; cfg_word = WORD_W'($urandom);
            @(negedge cclk);
        end
        cfg_valid = 1'b0;
        check("partial_no_cen", cen_cycles - c_partial, 0);
        for (int i = 0; i < NWORDS; i++) words[i] = '1;
        run_load(1'b0, 1'b0);
        check("ones_cc", config_use_cc, 1);
        check("ones_luts", luts_config_in, {LUT_BITS{1'b1}});

        // Async reset on the first cen cycle, then idle behaviour.
        for (int i = 0; i < NWORDS; i++) words[i] = WORD_W'($urandom);
        run_load(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1; cfg_word = WORD_W'($urandom);
            @(negedge cclk);
            check_zero("after_reset_idle");
        end
        cfg_valid = 1'b0;

        // Recovery: a fresh random load after the reset.
        for (int i = 0; i < NWORDS; i++) words[i] = WORD_W'($urandom);
        run_load(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
